// File: rtl/hdb3_pkg.sv
// Shared HDB3 definitions: line codes, pipeline stage types and window depth.
// Used by both hdb3_encode and hdb3_decode.
package hdb3_pkg;

   localparam logic [1:0] HDB3_ZERO = 2'b00;
   localparam logic [1:0] HDB3_POS  = 2'b01;
   localparam logic [1:0] HDB3_NEG  = 2'b10;

   localparam int HDB3_WIN = 4;

   typedef enum logic [1:0] {
      ST_ZERO  = 2'b00,
      ST_MARK  = 2'b01,
      ST_BCAND = 2'b10,
      ST_VIOL  = 2'b11
   } stage_type_e;

   typedef struct packed {
      stage_type_e typ;
      logic        vld;
   } stage_t;

   localparam stage_t STAGE_EMPTY = '{typ: ST_ZERO, vld: 1'b0};

   // pos = 1 selects +1, pos = 0 selects -1.
   function automatic logic [1:0] pol_to_code(input logic pos);
      return pos ? HDB3_POS : HDB3_NEG;
   endfunction

endpackage

// File: rtl/hdb3_pol_sel.sv
// HDB3 polarity selector: tracks last pulse polarity and pulse parity since the
// last violation, and maps the oldest stage type to a ternary line code.
module hdb3_pol_sel
   import hdb3_pkg::*;
#(
   parameter logic INIT_LAST_POS = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_adv,
   input  stage_type_e i_type,
   output logic [1:0]  o_code
);

   logic last_pol;
   logic last_pol_nxt;
   logic pulse_parity;
   logic pulse_parity_nxt;

   always_comb begin
      o_code           = HDB3_ZERO;
      last_pol_nxt     = last_pol;
      pulse_parity_nxt = pulse_parity;
      case (i_type)
         ST_MARK: begin
            o_code           = pol_to_code(~last_pol);
            last_pol_nxt     = ~last_pol;
            pulse_parity_nxt = ~pulse_parity;
         end
         ST_BCAND: begin
            // A B pulse is only needed when the pulse count since the last V is even.
            if (!pulse_parity) begin
               o_code           = pol_to_code(~last_pol);
               last_pol_nxt     = ~last_pol;
               pulse_parity_nxt = 1'b1;
            end
         end
         ST_VIOL: begin
            o_code           = pol_to_code(last_pol);
            pulse_parity_nxt = 1'b0;
         end
         default: begin
            o_code = HDB3_ZERO;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         last_pol     <= INIT_LAST_POS;
         pulse_parity <= 1'b0;
      end else if (i_adv) begin
         last_pol     <= last_pol_nxt;
         pulse_parity <= pulse_parity_nxt;
      end
   end

endmodule

// File: rtl/hdb3_encode.sv
// HDB3 line encoder: 4-stage look-ahead delay line with zero-run substitution,
// polarity resolved at the output. Optional AMI bypass: HDB3_AMI_BYPASS_EN.
module hdb3_encode
   import hdb3_pkg::*;
#(
   parameter logic INIT_LAST_POS = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
`ifdef HDB3_AMI_BYPASS_EN
   input  logic       i_ami_mode,
`endif
   input  logic       i_data,
   input  logic       i_data_vld,
   output logic [1:0] o_hdb3_code,
   output logic       o_code_vld
);

   // Strobe semantics: i_data is consumed on every cycle i_data_vld is high (no
   // backpressure); o_code_vld pulses for one cycle per emitted symbol.

   stage_t      stg     [HDB3_WIN];
   stage_t      stg_nxt [HDB3_WIN];
   logic        ami_en;
   logic        zero_run;
   logic        out_adv;
   logic [1:0]  sel_code;

`ifdef HDB3_AMI_BYPASS_EN
   assign ami_en = i_ami_mode;
`else
   assign ami_en = 1'b0;
`endif

   // Substituted stages are never ZERO, so back-to-back runs cannot overlap.
   always_comb begin
      zero_run = !i_data && !ami_en;
      for (int i = 0; i < HDB3_WIN - 1; i++) begin
         zero_run = zero_run && stg[i].vld && (stg[i].typ == ST_ZERO);
      end
   end

   always_comb begin
      for (int i = 0; i < HDB3_WIN; i++) begin
         stg_nxt[i] = stg[i];
      end
      if (i_data_vld) begin
         for (int i = HDB3_WIN - 1; i > 0; i--) begin
            stg_nxt[i] = stg[i-1];
         end
         stg_nxt[0] = '{typ: (i_data ? ST_MARK : ST_ZERO), vld: 1'b1};
         if (zero_run) begin
            stg_nxt[0].typ          = ST_VIOL;
            stg_nxt[HDB3_WIN-1].typ = ST_BCAND;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < HDB3_WIN; i++) begin
            stg[i] <= STAGE_EMPTY;
         end
      end else begin
         for (int i = 0; i < HDB3_WIN; i++) begin
            stg[i] <= stg_nxt[i];
         end
      end
   end

   assign out_adv = i_data_vld && stg[HDB3_WIN-1].vld;

   hdb3_pol_sel #(
      .INIT_LAST_POS (INIT_LAST_POS)
   ) u_pol_sel (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_adv   (out_adv),
      .i_type  (stg[HDB3_WIN-1].typ),
      .o_code  (sel_code)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_hdb3_code <= HDB3_ZERO;
         o_code_vld  <= 1'b0;
      end else begin
         o_code_vld <= out_adv;
         if (out_adv) begin
            o_hdb3_code <= sel_code;
         end
      end
   end

endmodule

// File: tb/tb_hdb3_encode.sv
// Self-checking bench for hdb3_encode: reference HDB3 model feeds a scoreboard
// queue; directed patterns, strobe gaps, mid-stream reset, optional AMI mode.
module tb_hdb3_encode;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       data = 1'b0;
   logic       dvld = 1'b0;
   logic       ami = 1'b0;
   logic [1:0] code;
   logic       cvld;

   int n_pass = 0;
   int n_chk  = 0;
   int vld_cnt;
   int zrun;
   int idx;
   logic [1:0] prev_code;

   bit         seq[$];
   logic [1:0] mdl[$];
   logic [1:0] exp_q[$];
   logic [1:0] act_q[$];
   logic [1:0] lit_q[$];
   logic [1:0] ref_q[$];

   hdb3_encode dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
`ifdef HDB3_AMI_BYPASS_EN
      .i_ami_mode  (ami),
`endif
      .i_data      (data),
      .i_data_vld  (dvld),
      .o_hdb3_code (code),
      .o_code_vld  (cvld)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Reference encoder over the whole bit sequence: on the 4th zero of a run,
   // rewrite the run in place as 000V or B00V.
   task automatic build_model();
      logic last;
      int   par;
      int   zc;
      last = 1'b0;
      par  = 0;
      zc   = 0;
      mdl.delete();
      foreach (seq[i]) begin
         if (seq[i]) begin
            mdl.push_back(last ? 2'b10 : 2'b01);
            last = ~last;
            par  = par ^ 1;
            zc   = 0;
         end else begin
            mdl.push_back(2'b00);
            zc++;
            if (zc == 4 && !ami) begin
               if (par == 0) begin
                  mdl[i-3] = last ? 2'b10 : 2'b01;
                  last = ~last;
               end
               mdl[i] = last ? 2'b01 : 2'b10;
               par = 0;
               zc  = 0;
            end
         end
      end
   endtask

   task automatic monitor();
      if (cvld) begin
         vld_cnt++;
         act_q.push_back(code);
         if (exp_q.size() == 0) chk("unexpected_vld", 1, 0);
         else chk("code", code, exp_q.pop_front());
         if (code == 2'b00) begin
            zrun++;
            if (!ami) chk("zero_run_le3", (zrun <= 3), 1);
         end else begin
            zrun = 0;
         end
      end else begin
         chk("hold_when_idle", code, prev_code);
      end
      prev_code = code;
   endtask

   task automatic step(input bit d, input bit v);
      @(negedge clk);
      monitor();
      data = d;
      dvld = v;
      if (v) begin
         exp_q.push_back(mdl[idx]);
         idx++;
      end
   endtask

   task automatic clear_sb();
      exp_q.delete();
      act_q.delete();
      vld_cnt   = 0;
      zrun      = 0;
      idx       = 0;
      prev_code = 2'b00;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      data  = 1'b0;
      dvld  = 1'b0;
      @(negedge clk);
      chk("rst_code", code, 2'b00);
      chk("rst_vld", cvld, 1'b0);
      rst_n = 1'b1;
      clear_sb();
   endtask

   // Drives seq (last 4 entries are padding that stays in flight).
   task automatic drive_seq(input bit gaps);
      build_model();
      foreach (seq[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) step(bit'($urandom_range(0, 1)), 1'b0);
         step(seq[i], 1'b1);
      end
      step(1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b0);
      chk("vld_count", vld_cnt, seq.size() - 4);
      chk("in_flight", exp_q.size(), 4);
   endtask

   task automatic cmp_lit(input string tag);
      chk({tag, "_len"}, act_q.size(), lit_q.size());
      for (int i = 0; i < lit_q.size() && i < act_q.size(); i++) chk(tag, act_q[i], lit_q[i]);
   endtask

   initial begin
      bit         dec[$];
      logic [1:0] lastp;
      clear_sb();

      // All ones: pure alternation
      seq = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      reset_dut();
      drive_seq(1'b0);
      lit_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      cmp_lit("ones");

      // Leading 0000 with even parity: B00V
      seq = '{0, 0, 0, 0, 1, 1, 1, 1, 1};
      reset_dut();
      drive_seq(1'b0);
      lit_q = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
      cmp_lit("b00v");

      // Single pulse then 0000: odd parity, 000V
      seq = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
      reset_dut();
      drive_seq(1'b0);
      lit_q = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
      cmp_lit("000v");

      // Two back-to-back runs, then decode the line back to bits
      seq = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
      reset_dut();
      drive_seq(1'b0);
      lit_q = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10};
      cmp_lit("two_runs");
      dec.delete();
      lastp = 2'b00;
      foreach (act_q[i]) begin
         dec.push_back(act_q[i] != 2'b00);
         if (act_q[i] != 2'b00) begin
            if (act_q[i] == lastp) begin
               dec[i] = 1'b0;
               if (i >= 3) dec[i-3] = 1'b0;
            end
            lastp = act_q[i];
         end
      end
      foreach (dec[i]) chk("decode", dec[i], seq[i]);

      // Random 64 bits, gap-free then with random strobe gaps
      seq.delete();
      repeat (64) seq.push_back(bit'($urandom_range(0, 1)));
      repeat (4) seq.push_back(1'b1);
      reset_dut();
      drive_seq(1'b0);
      ref_q = act_q;
      reset_dut();
      drive_seq(1'b1);
      lit_q = ref_q;
      cmp_lit("gaps_vs_nogaps");

      // Asynchronous reset in the middle of a zero run
      seq = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      reset_dut();
      build_model();
      for (int i = 0; i < 8; i++) step(seq[i], 1'b1);
      step(1'b0, 1'b0);
      chk("pre_rst_vld", cvld, 1'b1);
      chk("pre_rst_code", code, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_code", code, 2'b00);
      chk("async_rst_vld", cvld, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_sb();
      seq = '{0, 0, 0, 0, 1, 1, 1, 1};
      drive_seq(1'b0);
      lit_q = '{2'b01, 2'b00, 2'b00, 2'b01};
      cmp_lit("after_rst");

`ifdef HDB3_AMI_BYPASS_EN
      // AMI bypass: no substitution, same latency
      ami = 1'b1;
      seq = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
      reset_dut();
      drive_seq(1'b0);
      lit_q = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
      cmp_lit("ami");
      ami = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
